// File: rtl/opb_register_ppc2simulink_hs_if.sv
// Bus bundle for opb_register_ppc2simulink_hs: OPB slave signals plus the
// user-side valid/ack handshake. OPB vectors keep their big-endian [0:n]
// numbering; user_data_out uses conventional [31:0] numbering.
interface opb_register_ppc2simulink_hs_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;
  logic [31:0] user_data_out;
  logic        user_valid;
  logic        user_ack;

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr, user_ack,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup, user_data_out, user_valid
  );

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr, user_ack,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup, user_data_out, user_valid
  );
endinterface

// File: rtl/opb_register_ppc2simulink_hs.sv
// OPB slave carrying a 32-bit word from the PowerPC into fabric logic.
// Offset 0x0 = shadow DATA word, offset 0x4 = CTRL (commit / clear overrun,
// read back valid, overrun and 16-bit commit count). The committed word is
// handed to user logic with a valid/ack handshake.
// Optional feature macro PPC2SIM_AUTOCOMMIT_EN: every DATA write also commits.
module opb_register_ppc2simulink_hs #(
  parameter logic [31:0] C_BASEADDR    = 32'hFFFFFFFF,
  parameter logic [31:0] C_HIGHADDR    = 32'h00000000,
  parameter int          C_OPB_AWIDTH  = 32,
  parameter int          C_OPB_DWIDTH  = 32,
  parameter string       C_FAMILY      = "virtex5",
  parameter logic [31:0] C_RESET_VALUE = 32'h00000000
) (
  input logic OPB_Clk,
  input logic OPB_Rst,
  opb_register_ppc2simulink_hs_if.slave bus
);

  typedef enum logic {ST_IDLE, ST_ACK} state_t;

  state_t      state_q, state_d;
  logic [31:0] abus;
  logic        hit;
  logic [31:0] addr_q, data_q;
  logic [3:0]  be_q;         // be_q[3] = OPB_BE[0] = bits 31:24
  logic        rnw_q;
  logic [31:0] shadow_q, udo_q;
  logic        valid_q, ovr_q;
  logic [15:0] commit_count;
  logic [31:0] off;
  logic        sel_data, sel_ctrl, wr_en, wr_data, wr_ctrl;
  logic        commit, clr_ovr;
  logic [31:0] shadow_d;
  logic [31:0] rd_data;
  logic        unused_ok;

  assign abus = bus.OPB_ABus;
  assign hit  = bus.OPB_select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);

  // State register
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state: one ACK cycle per accepted hit, new hits only from IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hit) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the request when it is accepted
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      addr_q <= '0;
      data_q <= '0;
      be_q   <= '0;
      rnw_q  <= 1'b0;
    end else if (state_q == ST_IDLE && hit) begin
      addr_q <= bus.OPB_ABus;
      data_q <= bus.OPB_DBus;
      be_q   <= bus.OPB_BE;
      rnw_q  <= bus.OPB_RNW;
    end
  end

  // Decode the latched access and build the merged shadow / commit strobes
  always_comb begin
    off      = addr_q - C_BASEADDR;
    sel_data = (off[31:3] == 29'd0) && !off[2];
    sel_ctrl = (off[31:3] == 29'd0) &&  off[2];
    wr_en    = (state_q == ST_ACK) && !rnw_q;
    wr_data  = wr_en && sel_data;
    wr_ctrl  = wr_en && sel_ctrl && be_q[0];
    shadow_d = shadow_q;
    for (int b = 0; b < 4; b++)
      if (wr_data && be_q[b]) shadow_d[8*b +: 8] = data_q[8*b +: 8];
    clr_ovr  = wr_ctrl && data_q[1];
    commit   = wr_ctrl && data_q[0];
`ifdef PPC2SIM_AUTOCOMMIT_EN
    commit   = commit || wr_data;
`endif
  end

  // Shadow, committed word, handshake and status; a commit beats a
  // concurrent ack, and an overrun raised by a commit beats a clear
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      shadow_q     <= C_RESET_VALUE;
      udo_q        <= C_RESET_VALUE;
      valid_q      <= 1'b0;
      ovr_q        <= 1'b0;
      commit_count <= '0;
    end else begin
      shadow_q <= shadow_d;
      if (commit) begin
        udo_q        <= shadow_d;
        valid_q      <= 1'b1;
        commit_count <= commit_count + 16'd1;
      end else if (bus.user_ack) begin
        valid_q <= 1'b0;
      end
      if (commit && valid_q && !bus.user_ack) ovr_q <= 1'b1;
      else if (clr_ovr)                        ovr_q <= 1'b0;
    end
  end

  // Read data is only driven during a read ACK cycle
  always_comb begin
    rd_data = '0;
    if (state_q == ST_ACK && rnw_q) begin
      if (sel_data)      rd_data = shadow_q;
      else if (sel_ctrl) rd_data = {valid_q, ovr_q, 14'd0, commit_count};
    end
  end

  assign bus.Sl_DBus       = rd_data;
  assign bus.Sl_xferAck    = (state_q == ST_ACK);
  assign bus.Sl_errAck     = 1'b0;
  assign bus.Sl_retry      = 1'b0;
  assign bus.Sl_toutSup    = 1'b0;
  assign bus.user_data_out = udo_q;
  assign bus.user_valid    = valid_q;

  // Byte-lane address bits, seqAddr and informational parameters are not needed
  assign unused_ok = ^{off[1:0], bus.OPB_seqAddr, (C_OPB_AWIDTH != 0),
                       (C_OPB_DWIDTH != 0), (C_FAMILY != "")};

endmodule

// File: tb/tb_opb_register_ppc2simulink_hs.sv
// Bench for opb_register_ppc2simulink_hs: directed test-plan sequence with
// literal expectations, then randomized OPB traffic and user_ack, all
// compared every cycle against a transaction-level model of the register.
module tb_opb_register_ppc2simulink_hs;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] HIGH = 32'h4000_00FF;
  localparam logic [31:0] RV   = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  opb_register_ppc2simulink_hs_if bus();

  opb_register_ppc2simulink_hs #(
    .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
    .C_FAMILY("virtex5"), .C_RESET_VALUE(RV)
  ) dut (
    .OPB_Clk(clk), .OPB_Rst(rst), .bus(bus)
  );

  // model state
  logic [31:0] m_shadow, m_udo;
  logic        m_valid, m_ov;
  logic [15:0] m_cnt;
  logic        exp_ack;
  logic [31:0] exp_rd;
  logic        chk_en = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_shadow = RV; m_udo = RV; m_valid = 1'b0; m_ov = 1'b0; m_cnt = 16'd0;
    exp_ack = 1'b0; exp_rd = 32'd0;
  endtask

  // 0 = DATA, 1 = CTRL, 2 = unmapped (word-aligned addresses only)
  function automatic int kind(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    if (o == 32'd0) return 0;
    if (o == 32'd4) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (kind(a))
      0: return m_shadow;
      1: return {m_valid, m_ov, 14'd0, m_cnt};
      default: return 32'd0;
    endcase
  endfunction

  // One clock: user_ack held for the cycle, optional register write landing at its end
  task automatic cyc(input bit ua, input bit wr, input logic [31:0] a,
                     input logic [3:0] be, input logic [31:0] d);
    bit commit;
    bus.user_ack = ua;
    @(posedge clk); #1;
    commit = 1'b0;
    if (wr) begin
      if (kind(a) == 0) begin
        for (int b = 0; b < 4; b++) if (be[b]) m_shadow[8*b +: 8] = d[8*b +: 8];
`ifdef PPC2SIM_AUTOCOMMIT_EN
        commit = 1'b1;
`endif
      end else if (kind(a) == 1 && be[0]) begin
        if (d[1]) m_ov = 1'b0;
        if (d[0]) commit = 1'b1;
      end
    end
    if (commit) begin
      if (m_valid && !ua) m_ov = 1'b1;
      m_udo = m_shadow; m_valid = 1'b1; m_cnt = m_cnt + 16'd1;
    end else if (ua) begin
      m_valid = 1'b0;
    end
  endtask

  // Full OPB transfer; starts and ends on a falling edge
  task automatic xfer(input logic [31:0] a, input bit rnw, input logic [3:0] be,
                      input logic [31:0] d, input bit ua0, input bit ua1,
                      output logic [31:0] rd);
    bus.OPB_select = 1'b1; bus.OPB_ABus = a; bus.OPB_RNW = rnw;
    bus.OPB_BE = be; bus.OPB_DBus = d;
    cyc(ua0, 1'b0, a, be, d);
    exp_ack = 1'b1;
    exp_rd  = rnw ? model_read(a) : 32'd0;
    @(negedge clk);
    rd = bus.Sl_DBus;
    bus.OPB_select = 1'b0;
    cyc(ua1, !rnw, a, be, d);
    exp_ack = 1'b0; exp_rd = 32'd0;
    @(negedge clk);
  endtask

  task automatic idle(input bit ua, input bit probe, input logic [31:0] a);
    bus.OPB_select = probe; bus.OPB_ABus = a;
    cyc(ua, 1'b0, a, 4'h0, 32'd0);
    @(negedge clk);
    bus.OPB_select = 1'b0;
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("xferAck", {31'd0, bus.Sl_xferAck}, {31'd0, exp_ack});
      chk("Sl_DBus", bus.Sl_DBus, exp_rd);
      chk("user_data_out", bus.user_data_out, m_udo);
      chk("user_valid", {31'd0, bus.user_valid}, {31'd0, m_valid});
      chk("tied_zero", {29'd0, bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}, 32'd0);
    end
  end

  logic [31:0] rd, a, d;
  logic [3:0]  be;
  bit          rnw;
  int          k;

  initial begin
    bus.OPB_ABus = '0; bus.OPB_BE = '0; bus.OPB_DBus = '0; bus.OPB_RNW = 1'b0;
    bus.OPB_select = 1'b0; bus.OPB_seqAddr = 1'b0; bus.user_ack = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_udo", bus.user_data_out, RV);
    chk("rst_valid", {31'd0, bus.user_valid}, 32'd0);
    chk("rst_ack", {31'd0, bus.Sl_xferAck}, 32'd0);
    chk("rst_dbus", bus.Sl_DBus, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    xfer(BASE + 4, 1, 4'hF, 0, 0, 0, rd);
    chk("ctrl_after_rst", rd, 32'h0000_0000);

`ifndef PPC2SIM_AUTOCOMMIT_EN
    xfer(BASE, 0, 4'hF, 32'h12345678, 0, 0, rd);
    chk("valid_before_commit", {31'd0, bus.user_valid}, 32'd0);
    xfer(BASE + 4, 0, 4'hF, 32'h1, 0, 0, rd);
    chk("udo_commit", bus.user_data_out, 32'h12345678);
    chk("valid_commit", {31'd0, bus.user_valid}, 32'd1);
    xfer(BASE + 4, 1, 4'hF, 0, 0, 0, rd);
    chk("ctrl_one", rd, 32'h8000_0001);
    xfer(BASE, 0, 4'b0101, 32'hAABBCCDD, 0, 0, rd);
    xfer(BASE, 1, 4'hF, 0, 0, 0, rd);
    chk("be_merge", rd, 32'h12BB56DD);
    xfer(BASE + 4, 0, 4'hF, 32'h1, 0, 0, rd);
    xfer(BASE + 4, 1, 4'hF, 0, 0, 0, rd);
    chk("ctrl_overrun", rd, 32'hC000_0002);
    xfer(BASE + 4, 0, 4'hF, 32'h2, 0, 0, rd);
    xfer(BASE + 4, 1, 4'hF, 0, 0, 0, rd);
    chk("ctrl_clear", rd, 32'h8000_0002);
    idle(1, 0, 0);
    bus.user_ack = 1'b0;
    chk("ack_drops_valid", {31'd0, bus.user_valid}, 32'd0);
    xfer(BASE + 4, 0, 4'hF, 32'h1, 0, 0, rd);
    xfer(BASE + 4, 0, 4'hF, 32'h1, 0, 1, rd);
    xfer(BASE + 4, 1, 4'hF, 0, 0, 0, rd);
    chk("commit_with_ack", rd, 32'h8000_0004);
`else
    xfer(BASE, 0, 4'hF, 32'h11112222, 0, 0, rd);
    chk("auto_valid", {31'd0, bus.user_valid}, 32'd1);
    chk("auto_udo", bus.user_data_out, 32'h11112222);
    xfer(BASE + 4, 1, 4'hF, 0, 0, 0, rd);
    chk("auto_ctrl", rd, 32'h8000_0001);
`endif

    // commit counter wrap
    force dut.commit_count = 16'hFFFF;
    #1 release dut.commit_count;
    m_cnt = 16'hFFFF;
    xfer(BASE + 4, 0, 4'hF, 32'h1, 0, 1, rd);
    xfer(BASE + 4, 1, 4'hF, 0, 0, 0, rd);
    chk("count_wrap", {16'd0, rd[15:0]}, 32'd0);

    // unmapped in-window offset, and the window edges
    xfer(BASE + 8, 1, 4'hF, 0, 0, 0, rd);
    chk("offset8_read", rd, 32'd0);
    xfer(BASE + 8, 0, 4'hF, 32'hFFFF_FFFF, 0, 0, rd);
    xfer(BASE + 32'hFC, 1, 4'hF, 0, 0, 0, rd);
    idle(0, 1, HIGH + 1);
    idle(0, 1, BASE - 4);

    // reset during the ACK cycle aborts the write
    chk_en = 1'b0;
    bus.OPB_select = 1'b1; bus.OPB_ABus = BASE; bus.OPB_RNW = 1'b0;
    bus.OPB_BE = 4'hF; bus.OPB_DBus = 32'h5555_5555;
    @(posedge clk); #1;
    chk("ack_before_rst", {31'd0, bus.Sl_xferAck}, 32'd1);
    @(negedge clk);
    rst = 1'b1; bus.OPB_select = 1'b0;
    #1 chk("ack_aborted", {31'd0, bus.Sl_xferAck}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk_en = 1'b1;
    xfer(BASE, 1, 4'hF, 0, 0, 0, rd);
    chk("shadow_after_abort", rd, RV);

    // randomized traffic
    repeat (400) begin
      k = $urandom_range(0, 9);
      a = (k < 4) ? BASE + 32'(k) * 4 : BASE + 32'($urandom_range(0, 63)) * 4;
      rnw = 1'($urandom_range(0, 1));
      be = 4'($urandom);
      d = $urandom;
      if (kind(a) == 1 && $urandom_range(0, 1) == 1) d = 32'($urandom_range(0, 3));
      xfer(a, rnw, be, d, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, rd);
      k = $urandom_range(0, 5);
      if (k == 0) idle(1'($urandom_range(0, 1)), 0, 0);
      else if (k == 1) idle(1'($urandom_range(0, 1)), 1, HIGH + 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
